// File: rtl/multicycle_controller.sv
// Moore control FSM for the multicycle MIPS datapath, with the ALU decoder.
// Sequences memory, IR, register file, ALU and PC over 3-5 cycles per instruction.
module multicycle_controller (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] op,
   input  logic [5:0] funct,
   input  logic       zero,
   output logic       pc_en,
   output logic       i_or_d,
   output logic       mem_write,
   output logic       ir_write,
   output logic       mem_to_reg,
   output logic       reg_dst,
   output logic       reg_write,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] pc_src,
   output logic [2:0] alu_control,
   output logic [3:0] state
);

   typedef enum logic [3:0] {
      FETCH    = 4'd0,
      DECODE   = 4'd1,
      MEMADR   = 4'd2,
      MEMRD    = 4'd3,
      MEMWB    = 4'd4,
      MEMWR    = 4'd5,
      EXECUTE  = 4'd6,
      ALUWB    = 4'd7,
      BRANCH   = 4'd8,
      ADDIEXEC = 4'd9,
      ADDIWB   = 4'd10,
      JUMP     = 4'd11
   } state_t;

   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   state_t     state_q;
   state_t     state_d;
   state_t     cur;
   logic       funct_ok;
   logic [2:0] funct_alu;
   logic       pc_write;
   logic       branch;

   always_ff @(posedge clk) begin
      // NOTE: state registers take non-blocking assignments so every flop samples pre-edge values.
      if (reset) state_q <= FETCH;
      else       state_q <= state_d;
   end

   always_comb begin
      funct_ok  = 1'b1;
      funct_alu = 3'b010;
      case (funct)
         6'b100000: funct_alu = 3'b010;
         6'b100010: funct_alu = 3'b110;
         6'b100100: funct_alu = 3'b000;
         6'b100101: funct_alu = 3'b001;
         6'b101010: funct_alu = 3'b111;
         default:   funct_ok  = 1'b0;
      endcase
   end

   always_comb begin
      // NOTE: a default before the case keeps this purely combinational (no latch).
      state_d = FETCH;
      case (state_q)
         FETCH:  state_d = DECODE;
         DECODE: begin
            case (op)
               OP_LW, OP_SW: state_d = MEMADR;
               OP_RTYPE:     state_d = EXECUTE;
               OP_BEQ:       state_d = BRANCH;
               OP_ADDI:      state_d = ADDIEXEC;
               OP_J:         state_d = JUMP;
               default:      state_d = FETCH;
            endcase
         end
         MEMADR: begin
            if (op == OP_LW)      state_d = MEMRD;
            else if (op == OP_SW) state_d = MEMWR;
         end
         MEMRD:    state_d = MEMWB;
         EXECUTE:  state_d = funct_ok ? ALUWB : FETCH;
         ADDIEXEC: state_d = ADDIWB;
         default:  state_d = FETCH;
      endcase
   end

   // Under reset the datapath sees FETCH mux selects but no write enables.
   assign cur = reset ? FETCH : state_q;

   always_comb begin
      pc_write    = 1'b0;
      branch      = 1'b0;
      i_or_d      = 1'b0;
      mem_write   = 1'b0;
      ir_write    = 1'b0;
      mem_to_reg  = 1'b0;
      reg_dst     = 1'b0;
      reg_write   = 1'b0;
      alu_src_a   = 1'b0;
      alu_src_b   = 2'b00;
      pc_src      = 2'b00;
      alu_control = 3'b000;
      case (cur)
         FETCH: begin
            ir_write    = 1'b1;
            alu_src_b   = 2'b01;
            alu_control = 3'b010;
            pc_write    = 1'b1;
         end
         DECODE: begin
            alu_src_b   = 2'b11;
            alu_control = 3'b010;
         end
         MEMADR, ADDIEXEC: begin
            alu_src_a   = 1'b1;
            alu_src_b   = 2'b10;
            alu_control = 3'b010;
         end
         MEMRD: i_or_d = 1'b1;
         MEMWR: begin
            i_or_d    = 1'b1;
            mem_write = 1'b1;
         end
         MEMWB: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
         end
         EXECUTE: begin
            alu_src_a   = 1'b1;
            alu_control = funct_alu;
         end
         ALUWB: begin
            reg_write = 1'b1;
            reg_dst   = 1'b1;
         end
         ADDIWB: reg_write = 1'b1;
         BRANCH: begin
            alu_src_a   = 1'b1;
            alu_control = 3'b110;
            branch      = 1'b1;
            pc_src      = 2'b01;
         end
         JUMP: begin
            pc_write = 1'b1;
            pc_src   = 2'b10;
         end
         default: ;
      endcase
      if (reset) begin
         pc_write  = 1'b0;
         branch    = 1'b0;
         ir_write  = 1'b0;
         mem_write = 1'b0;
         reg_write = 1'b0;
      end
   end

   assign pc_en = pc_write | (branch & zero);
   assign state = state_q;

endmodule
